// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - byte FIFO behind the UART receiver with edge-detected writes and sticky overflow
module uart_rx_fifo #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              uart_done,
    input  logic [DATA_W-1:0] uart_data,
    input  logic              rd_en,
    input  logic              ovf_clr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   fifo_cnt,
    output logic              overflow
);

    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_cnt;
    logic              r_empty;
    logic              r_full;
    logic              r_overflow;
    logic              r_done_d0;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    logic              w_wr_pulse;
    logic              w_rd_accept;
    logic              w_wr_accept;
    logic              w_drop;
    logic [ADDR_W:0]   w_cnt_nxt;

    // The receiver holds done high for a whole byte time; only its rising edge writes.
    assign w_wr_pulse  = uart_done & ~r_done_d0;
    // Reads are gated by the registered empty flag, so a same-cycle write cannot fall through.
    assign w_rd_accept = rd_en & ~r_empty;
    // A read in the same cycle frees a slot, so a full FIFO can still take the byte.
    assign w_wr_accept = w_wr_pulse & (~r_full | w_rd_accept);
    assign w_drop      = w_wr_pulse & r_full & ~w_rd_accept;

    // Next fill level: write-only increments, read-only decrements, both cancel.
    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_wr_accept, w_rd_accept})
            2'b10:   w_cnt_nxt = r_cnt + CNT_ONE;
            2'b01:   w_cnt_nxt = r_cnt - CNT_ONE;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Delay uart_done one cycle for rising-edge detection.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_done_d0 <= 1'b0;
        else            r_done_d0 <= uart_done;
    end

    // Storage array; contents are meaningless until written, so it carries no reset.
    always_ff @(posedge sys_clk) begin
        if (w_wr_accept) r_mem[r_wptr] <= uart_data;
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_accept) r_wptr <= r_wptr + PTR_ONE;
            if (w_rd_accept) r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Count and flags are registered together from the same next value so they always agree.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt   <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_empty <= (w_cnt_nxt == '0);
            r_full  <= (w_cnt_nxt == CNT_FULL);
        end
    end

    // Registered pop: data and one-cycle strobe appear the cycle after acceptance; data holds otherwise.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_accept;
            if (w_rd_accept) r_rd_data <= r_mem[r_rptr];
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)   r_overflow <= 1'b0;
        else if (w_drop)  r_overflow <= 1'b1;
        else if (ovf_clr) r_overflow <= 1'b0;
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign empty    = r_empty;
    assign full     = r_full;
    assign fifo_cnt = r_cnt;
    assign overflow = r_overflow;

endmodule
